// File: rtl/mix_columns_seq.sv
// Forward AES MixColumns on a 128-bit state, COLS_PER_CYCLE columns per BUSY cycle.
// Valid/ready on both sides; all outputs come straight from flops.
module mix_columns_seq #(
    parameter int COLS_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [127:0] in_state,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [127:0] out_state,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         busy
);

    // Handshake: a transfer happens on a rising edge where valid && ready; the
    // source holds data and valid until then, and ready never depends on valid.

    generate
        if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cfg
            $error("mix_columns_seq: COLS_PER_CYCLE must be 1, 2 or 4");
        end
    endgenerate

    localparam logic [1:0] CNT_STEP = 2'(COLS_PER_CYCLE % 4);
    localparam logic [1:0] CNT_LAST = 2'(4 - COLS_PER_CYCLE);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e       state_q, state_d;
    logic [1:0]   cnt_q, cnt_d;
    logic [127:0] src_q, src_d;
    logic [127:0] res_q, res_d;
    logic         out_valid_q, out_valid_d;
    logic         busy_q, busy_d;
    logic         in_ready_q, in_ready_d;

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1B : 8'h00);
    endfunction

    function automatic logic [7:0] m3(input logic [7:0] a);
        return xt(a) ^ a;
    endfunction

    // Column bits [31:24] hold row 0.
    function automatic logic [31:0] mix_col(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        a0 = col[31:24];
        a1 = col[23:16];
        a2 = col[15:8];
        a3 = col[7:0];
        return {xt(a0) ^ m3(a1) ^ a2     ^ a3,
                a0     ^ xt(a1) ^ m3(a2) ^ a3,
                a0     ^ a1     ^ xt(a2) ^ m3(a3),
                m3(a0) ^ a1     ^ a2     ^ xt(a3)};
    endfunction

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        src_d   = src_q;
        res_d   = res_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    src_d   = in_state;
                    res_d   = '0;
                    cnt_d   = 2'd0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                // cnt_q is always a multiple of COLS_PER_CYCLE, so cnt_q+i stays within 0..3.
                for (int i = 0; i < COLS_PER_CYCLE; i++) begin
                    res_d[127 - 32*(int'(cnt_q) + i) -: 32] =
                        mix_col(src_q[127 - 32*(int'(cnt_q) + i) -: 32]);
                end
                cnt_d = cnt_q + CNT_STEP;
                if (cnt_q == CNT_LAST) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        in_ready_d  = (state_d == IDLE);
        busy_d      = (state_d != IDLE);
        out_valid_d = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= 2'd0;
            src_q       <= '0;
            res_q       <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            src_q       <= src_d;
            res_q       <= res_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            in_ready_q  <= in_ready_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_state = res_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;

endmodule
